// File: rtl/key_pkg.sv
// Shared definitions for the key event controller: FSM state encoding,
// default timing constants and the timer threshold helper.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } key_state_e;

    // Defaults assume a 50 MHz sys_clk.
    localparam logic [19:0] KEY_CNT_MAX_DEF  = 20'd999_999;
    localparam logic [25:0] KEY_LONG_MAX_DEF = 26'd49_999_999;
    localparam logic [25:0] KEY_DBL_MAX_DEF  = 26'd14_999_999;
    localparam logic [25:0] KEY_REP_MAX_DEF  = 26'd9_999_999;

    // True on the last cycle of a window of lim cycles counted from 0.
    function automatic logic tmr_hit(input logic [25:0] tmr, input logic [25:0] lim);
        return (tmr == (lim - 26'd1));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-time debounce for an active-low key.
// Emits one-cycle registered pulses when the debounced level changes.
module key_debounce
    import key_pkg::*;
#(
    parameter logic [19:0] CNT_MAX = KEY_CNT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key,
    output logic o_press,
    output logic o_release
);

    logic [1:0]  r_sync;
    logic        r_stable;
    logic [19:0] r_cnt;
    logic        r_press;
    logic        r_release;

    // Synchronize, then accept a new level only after CNT_MAX consecutive disagreeing cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync    <= 2'b11;
            r_stable  <= 1'b1;
            r_cnt     <= 20'd0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_key};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= 20'd0;
            end else if (r_cnt == (CNT_MAX - 20'd1)) begin
                r_cnt     <= 20'd0;
                r_stable  <= r_sync[1];
                r_press   <= ~r_sync[1];
                r_release <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_event_ctrl.sv
// Key event classifier: short press, double click, long press and hold level.
// Define KEY_REPEAT_EN to re-pulse key_long every REP_MAX cycles while held long.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = KEY_CNT_MAX_DEF,
    parameter logic [25:0] LONG_MAX = KEY_LONG_MAX_DEF,
    parameter logic [25:0] DBL_MAX  = KEY_DBL_MAX_DEF,
    parameter logic [25:0] REP_MAX  = KEY_REP_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_short,
    output logic key_double,
    output logic key_long,
    output logic key_hold
);

    logic        w_press;
    logic        w_release;
    key_state_e  r_state;
    logic [25:0] r_tmr;
    logic        r_short;
    logic        r_double;
    logic        r_long;
    logic        r_hold;

    key_debounce #(
        .CNT_MAX (CNT_MAX)
    ) u_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_key     (key_in),
        .o_press   (w_press),
        .o_release (w_release)
    );

`ifndef KEY_REPEAT_EN
    logic w_rep_unused;
    assign w_rep_unused = ^REP_MAX;
`endif

    // Classification FSM; events take priority over timer thresholds in every state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_tmr    <= 26'd0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmr <= 26'd0;
                    if (w_press) begin
                        r_state <= ST_PRESS1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PRESS1: begin
                    if (w_release) begin
                        r_state <= ST_WAIT2;
                        r_tmr   <= 26'd0;
                    end else if (tmr_hit(r_tmr, LONG_MAX)) begin
                        r_state <= ST_LONG;
                        r_tmr   <= 26'd0;
                        r_long  <= 1'b1;
                        r_hold  <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + 26'd1;
                    end
                end
                ST_WAIT2: begin
                    if (w_press) begin
                        r_state <= ST_PRESS2;
                        r_tmr   <= 26'd0;
                    end else if (tmr_hit(r_tmr, DBL_MAX)) begin
                        r_state <= ST_IDLE;
                        r_tmr   <= 26'd0;
                        r_short <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + 26'd1;
                    end
                end
                ST_PRESS2: begin
                    r_tmr <= 26'd0;
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_double <= 1'b1;
                    end else begin
                        r_state <= ST_PRESS2;
                    end
                end
                ST_LONG: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_tmr   <= 26'd0;
                        r_hold  <= 1'b0;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (tmr_hit(r_tmr, REP_MAX)) begin
                            r_tmr  <= 26'd0;
                            r_long <= 1'b1;
                        end else begin
                            r_tmr <= r_tmr + 26'd1;
                        end
`else
                        r_tmr <= 26'd0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tmr   <= 26'd0;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign key_short  = r_short;
    assign key_double = r_double;
    assign key_long   = r_long;
    assign key_hold   = r_hold;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short timing constants.
// Key changes are driven on the falling edge; sample index = rising-edge count.
module tb_key_event_ctrl;

    // Latency from the rising edge that first samples a key change to the
    // edge where the FSM consumes the debounced event: 2 sync + 24 count.
    localparam int DEB_LAT = 26;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_in    = 1'b1;
    logic key_short;
    logic key_double;
    logic key_long;
    logic key_hold;

    key_event_ctrl #(
        .CNT_MAX  (20'd24),
        .LONG_MAX (26'd200),
        .DBL_MAX  (26'd100),
        .REP_MAX  (26'd50)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_in     (key_in),
        .key_short  (key_short),
        .key_double (key_double),
        .key_long   (key_long),
        .key_hold   (key_hold)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int   cnt_short = 0, cnt_double = 0, cnt_long = 0, multi = 0;
    int   last_short = -1, last_double = -1, last_long = -1;
    int   hold_rise = -1, hold_fall = -1;
    logic hold_q = 1'b0;
    always @(negedge sys_clk) begin
        if (key_short)  begin cnt_short  <= cnt_short + 1;  last_short  <= cyc; end
        if (key_double) begin cnt_double <= cnt_double + 1; last_double <= cyc; end
        if (key_long)   begin cnt_long   <= cnt_long + 1;   last_long   <= cyc; end
        if (int'(key_short) + int'(key_double) + int'(key_long) > 1) multi <= multi + 1;
        if (key_hold && !hold_q) hold_rise <= cyc;
        if (!key_hold && hold_q) hold_fall <= cyc;
        hold_q <= key_hold;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hold key at level v for n sampling edges; smp = first sampling edge.
    task automatic seg(input logic v, input int n, output int smp);
        @(negedge sys_clk);
        key_in = v;
        smp = cyc + 1;
        repeat (n - 1) @(negedge sys_clk);
    endtask

    // 30 cycles of 3-cycle bounce, leaving the key at the opposite of v.
    task automatic bounce_from(input logic v);
        int d;
        for (int k = 0; k < 10; k++) seg((k % 2 == 0) ? v : ~v, 3, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s_short", tag),  int'(key_short),  0);
        check($sformatf("%s_double", tag), int'(key_double), 0);
        check($sformatf("%s_long", tag),   int'(key_long),   0);
        check($sformatf("%s_hold", tag),   int'(key_hold),   0);
    endtask

    typedef struct {
        string name;
        bit    bounce;
        int    len1;
        int    gap;
        int    len2;
        int    e_short;
        int    e_double;
        int    e_long;
        bit    e_hold;
    } vec_t;

`ifdef KEY_REPEAT_EN
    localparam int LONG_N = 4;
    localparam int LONG_N_C = 2;
`else
    localparam int LONG_N = 1;
    localparam int LONG_N_C = 1;
`endif

    vec_t vecs[6];

    initial begin
        int s_first, r_last, s2, d;
        int b_short, b_double, b_long, b_multi;

        vecs[0] = '{"short_bounce", 1'b1, 150, 0,  0,  1, 0, 0,      1'b0};
        vecs[1] = '{"double",       1'b0, 60,  50, 60, 0, 1, 0,      1'b0};
        vecs[2] = '{"long_hold",    1'b0, 400, 0,  0,  0, 0, LONG_N, 1'b1};
        vecs[3] = '{"glitch10",     1'b0, 10,  0,  0,  0, 0, 0,      1'b0};
        vecs[4] = '{"glitch23",     1'b0, 23,  0,  0,  0, 0, 0,      1'b0};
        vecs[5] = '{"pulse24",      1'b0, 24,  0,  0,  1, 0, 0,      1'b0};

        // Reset state
        repeat (3) @(negedge sys_clk);
        check_outputs_zero("reset");
        sys_rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            b_short = cnt_short; b_double = cnt_double; b_long = cnt_long; b_multi = multi;
            if (vecs[i].bounce) bounce_from(1'b0);
            seg(1'b0, vecs[i].len1, s_first);
            if (vecs[i].bounce) bounce_from(1'b1);
            seg(1'b1, (vecs[i].len2 > 0) ? vecs[i].gap : 1, r_last);
            if (vecs[i].len2 > 0) begin
                seg(1'b0, vecs[i].len2, s2);
                seg(1'b1, 1, r_last);
            end
            idle(450);
            check({vecs[i].name, "_n_short"},  cnt_short - b_short,   vecs[i].e_short);
            check({vecs[i].name, "_n_double"}, cnt_double - b_double, vecs[i].e_double);
            check({vecs[i].name, "_n_long"},   cnt_long - b_long,     vecs[i].e_long);
            check({vecs[i].name, "_onehot"},   multi - b_multi,       0);
            if (vecs[i].e_short > 0)
                check({vecs[i].name, "_t_short"}, last_short, r_last + DEB_LAT + 100);
            if (vecs[i].e_double > 0)
                check({vecs[i].name, "_t_double"}, last_double, r_last + DEB_LAT);
            if (vecs[i].e_long > 0)
                check({vecs[i].name, "_t_long"}, last_long,
                      s_first + DEB_LAT + 200 + 50 * (vecs[i].e_long - 1));
            if (vecs[i].e_hold) begin
                check({vecs[i].name, "_hold_rise"}, hold_rise, s_first + DEB_LAT + 200);
                check({vecs[i].name, "_hold_fall"}, hold_fall, r_last + DEB_LAT);
            end
        end

        // Asynchronous reset while in the long-press state
        seg(1'b0, 300, s_first);
        check("long_hold_before_rst", int'(key_hold), 1);
        #2 sys_rst_n = 1'b0;
        #1 check_outputs_zero("rst_in_long");
        b_short = cnt_short; b_double = cnt_double; b_long = cnt_long;
        seg(1'b1, 3, d);
        sys_rst_n = 1'b1;
        idle(450);
        check("rst_long_no_short", cnt_short - b_short, 0);
        check("rst_long_no_long",  cnt_long - b_long,   0);

        // Reset 100 cycles into PRESS1, key kept low briefly then released
        b_short = cnt_short; b_double = cnt_double; b_long = cnt_long;
        seg(1'b0, 126, s_first);
        #2 sys_rst_n = 1'b0;
        #1 check_outputs_zero("rst_in_press1");
        idle(2);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(10);
        seg(1'b1, 1, r_last);
        idle(450);
        check("rst_press_no_short",  cnt_short - b_short,   0);
        check("rst_press_no_long",   cnt_long - b_long,     0);
        check("rst_press_no_double", cnt_double - b_double, 0);

        // Key held across reset deassertion: press debounced afresh
        seg(1'b0, 5, d);
        sys_rst_n = 1'b0;
        b_long = cnt_long;
        idle(2);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        s_first = cyc + 1;
        idle(300);
        seg(1'b1, 1, r_last);
        idle(450);
        check("held_rst_n_long",    cnt_long - b_long, LONG_N_C);
        check("held_rst_hold_rise", hold_rise, s_first + DEB_LAT + 200);

        // Second press consumed exactly when WAIT2 timer reaches 99
        b_short = cnt_short; b_double = cnt_double;
        seg(1'b0, 60, s_first);
        seg(1'b1, 100, r_last);
        seg(1'b0, 60, s2);
        check("edge_press_offset", s2 - r_last, 100);
        seg(1'b1, 1, r_last);
        idle(450);
        check("edge_n_short",  cnt_short - b_short,   0);
        check("edge_n_double", cnt_double - b_double, 1);
        check("edge_t_double", last_double, r_last + DEB_LAT);
        check("total_onehot",  multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
